// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand and result handshake bundle for serial_add_ctrl.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
// slave  = the adder controller's view, master = the producer/consumer side.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef SERIAL_ADD_OVF_EN
        , output ovf
`endif
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef SERIAL_ADD_OVF_EN
        , input ovf
`endif
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller. One full-adder cell is reused
// over WIDTH cycles, LSB first, with a registered carry between bits.
// Optional feature macro: SERIAL_ADD_OVF_EN (adds the signed overflow flag ovf).
//
//  state | meaning
//  IDLE  | ready for operands, last result still visible on sum/cout
//  ADD   | one bit per cycle through the shared full adder
//  HOLD  | result presented (out_valid), waiting for out_ready
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;

    state_t           state;
    state_t           state_nx;
    logic             in_ready_c;
    logic             out_valid_c;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_nx;
    logic             carry;
    logic             cout_r;
    logic             s_bit;
    logic             c_nx;
    logic [CW-1:0]    cnt;
    logic             last_bit;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_r;
`endif

    // Shared full-adder cell; the new sum bit enters at the MSB so the
    // finished word lands aligned after WIDTH shifts (also valid for WIDTH=1).
    always_comb begin
        s_bit            = a_sh[0] ^ b_sh[0] ^ carry;
        c_nx             = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        sum_nx           = sum_r >> 1;
        sum_nx[WIDTH-1]  = s_bit;
    end

    assign last_bit = (cnt == LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx    = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_nx = ADD;
                end
            end
            ADD: begin
                if (last_bit) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand shift registers, carry, bit counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    sum_r <= sum_nx;
                    carry <= c_nx;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        cout_r <= c_nx;
`ifdef SERIAL_ADD_OVF_EN
                        // carry still holds the carry into the MSB here
                        ovf_r  <= carry ^ c_nx;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf       = ovf_r;
`endif

endmodule
